uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of the parallel data word.
REQ-002 CLK  input  1  transmit bit clock; one serial bit per CLK period; all state updates on the rising edge.
REQ-003 RST  input  1  reset; synchronous, active-high.
REQ-004 P_DATA  input  DATA_WIDTH  parallel byte to transmit; sampled only on acceptance.
REQ-005 DATA_VALID  input  1  P_DATA holds a byte to send (e.g. FIFO non-empty).
REQ-006 PAR_EN  input  1  1 = append a parity bit; sampled only on acceptance.
REQ-007 PAR_TYP  input  1  0 = even parity, 1 = odd parity; sampled only on acceptance.
REQ-008 TX_OUT  output  1  serial line, idle high; registered.
REQ-009 Busy  output  1  high while a frame is on the line; registered; upstream read strobe derives from it.

Function
REQ-010 States SHALL be IDLE, START, DATA, PARITY, STOP, held in one state register.
REQ-011 Acceptance SHALL occur at a rising edge where state = IDLE and DATA_VALID = 1; P_DATA, PAR_EN and PAR_TYP are latched at that edge.
REQ-012 Accepting edge k: TX_OUT = 0 (start bit) and Busy = 1 from edge k to k+1; state START.
REQ-013 DATA: edges k+1 .. k+DATA_WIDTH drive latched data LSB first, one bit per cycle, counted by a log2(DATA_WIDTH)-bit bit counter that resets to 0 on entering DATA.
REQ-014 PARITY (only if latched PAR_EN = 1): one cycle carrying XOR of latched data (even) or its inverse (odd).
REQ-015 STOP: one cycle with TX_OUT = 1, Busy = 1; next edge returns to IDLE unconditionally.
REQ-016 Frame length SHALL be DATA_WIDTH+2 cycles without parity and DATA_WIDTH+3 with parity.
REQ-017 IDLE: TX_OUT = 1, Busy = 0.
REQ-018 No acceptance outside IDLE: at least one IDLE cycle separates consecutive frames, even with DATA_VALID held high.
REQ-019 Changes on P_DATA, PAR_EN, PAR_TYP or DATA_VALID during a frame SHALL not affect the frame in progress.
REQ-020 Parity SHALL be computed from the latched word, never from live P_DATA.
REQ-021 TX_OUT and Busy SHALL be flop outputs with no combinational path from any input.

Reset
REQ-022 RST = 1 at a rising edge SHALL force state IDLE, TX_OUT = 1, Busy = 0, bit counter = 0, latched data = 0, latched PAR_EN/PAR_TYP = 0.
REQ-023 RST mid-frame SHALL abort the frame at that edge with no stop bit; the interrupted byte is not retransmitted.
REQ-024 RST has priority over DATA_VALID at the same edge: no acceptance.
REQ-025 Acceptance is possible at the first edge after RST deasserts.

Verification
REQ-026 P_DATA = 0xA5, PAR_EN = 0, one-cycle DATA_VALID -> TX_OUT = 0,1,0,1,0,0,1,0,1,1 over 10 cycles; Busy high exactly those 10 cycles.
REQ-027 0xA5, PAR_EN = 1, PAR_TYP = 0 -> parity bit 0, 11-cycle frame; repeat with PAR_TYP = 1 -> parity bit 1.
REQ-028 DATA_VALID held high, P_DATA = 0x3C then 0xC3 -> two frames separated by exactly one idle cycle (TX_OUT = 1, Busy = 0).
REQ-029 P_DATA changed to 0xFF and PAR_TYP toggled during the frame of 0x00 -> line shows 0x00 data bits and the originally latched parity.
REQ-030 RST pulsed for one cycle during data bit 3 -> next cycle TX_OUT = 1, Busy = 0, IDLE; a new byte accepted right after transmits a complete frame.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: serial transmitter, one bit per CLK period.
// Frame: start bit (0), DATA_WIDTH data bits LSB first, optional parity bit, stop bit (1).
// Ports:
//   CLK        - bit clock, all state on rising edge
//   RST        - synchronous active-high reset
//   P_DATA     - parallel word, latched on acceptance
//   DATA_VALID - word available; accepted only in idle
//   PAR_EN     - append parity bit (latched on acceptance)
//   PAR_TYP    - 0 even, 1 odd parity (latched on acceptance)
//   TX_OUT     - registered serial line, idle high
//   Busy       - registered, high while a frame is on the line
module uart_tx #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int unsigned     CntW    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    par_en_q, par_en_d;
    logic                    par_typ_q, par_typ_d;
    logic                    tx_q, tx_d;
    logic                    busy_q, busy_d;
    logic [CntW-1:0]         cnt_inc;
    logic                    parity_bit;

    assign cnt_inc    = cnt_q + CntW'(1);
    // Parity always from the latched word, never the live input.
    assign parity_bit = (^data_q) ^ par_typ_q;

    // Outputs are registered: tx_d/busy_d describe the cycle that begins at the next edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        tx_d      = 1'b1;
        busy_d    = 1'b0;

        case (state_q)
            StIdle: begin
                if (DATA_VALID) begin
                    state_d   = StStart;
                    data_d    = P_DATA;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            StStart: begin
                state_d = StData;
                cnt_d   = '0;
                tx_d    = data_q[0];
                busy_d  = 1'b1;
            end
            StData: begin
                busy_d = 1'b1;
                if (cnt_q == LastBit) begin
                    if (par_en_q) begin
                        state_d = StParity;
                        tx_d    = parity_bit;
                    end else begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    tx_d  = data_q[cnt_inc];
                end
            end
            StParity: begin
                state_d = StStop;
                tx_d    = 1'b1;
                busy_d  = 1'b1;
            end
            StStop: begin
                // Returning to idle guarantees at least one idle cycle between frames.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx with a per-cycle expected-output queue.
module tb_uart_tx;

    localparam int unsigned DW = 8;

    logic          clk;
    logic          RST;
    logic [DW-1:0] P_DATA;
    logic          DATA_VALID;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic          TX_OUT;
    logic          Busy;

    int checks = 0;
    int errors = 0;

    // Each entry is {TX_OUT, Busy} expected for one bit cycle.
    logic [1:0] exp_q[$];

    uart_tx #(
        .DATA_WIDTH(DW)
    ) dut (
        .CLK       (clk),
        .RST       (RST),
        .P_DATA    (P_DATA),
        .DATA_VALID(DATA_VALID),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .TX_OUT    (TX_OUT),
        .Busy      (Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void push_frame(input logic [DW-1:0] d, input logic pe, input logic pt);
        int ones;
        ones = 0;
        exp_q.push_back(2'b01);
        for (int i = 0; i < int'(DW); i++) begin
            exp_q.push_back({d[i], 1'b1});
            if (d[i]) ones++;
        end
        if (pe) exp_q.push_back({((ones % 2) == 1) ^ pt, 1'b1});
        exp_q.push_back(2'b11);
    endfunction

    function automatic void push_idle();
        exp_q.push_back(2'b10);
    endfunction

    task automatic test_reset();
        logic [1:0] exp;
        exp = 2'b10;
        @(negedge clk);
        checks++;
        if ({TX_OUT, Busy} !== exp) begin
            errors++;
            $display("FAIL reset_state: tx/busy=%b expected %b", {TX_OUT, Busy}, exp);
        end
        P_DATA     = 8'hA5;
        DATA_VALID = 1'b1;
        @(negedge clk);
        checks++;
        if ({TX_OUT, Busy} !== exp) begin
            errors++;
            $display("FAIL reset_priority: tx/busy=%b expected %b", {TX_OUT, Busy}, exp);
        end
        RST        = 1'b0;
        DATA_VALID = 1'b0;
        @(negedge clk);
        checks++;
        if ({TX_OUT, Busy} !== exp) begin
            errors++;
            $display("FAIL idle_after_reset: tx/busy=%b expected %b", {TX_OUT, Busy}, exp);
        end
    endtask

    task automatic test_no_parity();
        logic [1:0] exp;
        int         i;
        P_DATA     = 8'hA5;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        DATA_VALID = 1'b1;
        push_frame(8'hA5, 1'b0, 1'b0);
        push_idle();
        @(negedge clk);
        DATA_VALID = 1'b0;
        i = 0;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            checks++;
            if ({TX_OUT, Busy} !== exp) begin
                errors++;
                $display("FAIL no_parity cycle %0d: tx/busy=%b expected %b", i, {TX_OUT, Busy}, exp);
            end
            i++;
            @(negedge clk);
        end
    endtask

    task automatic test_parity(input logic pt);
        logic [1:0] exp;
        int         i;
        P_DATA     = 8'hA5;
        PAR_EN     = 1'b1;
        PAR_TYP    = pt;
        DATA_VALID = 1'b1;
        push_frame(8'hA5, 1'b1, pt);
        push_idle();
        @(negedge clk);
        DATA_VALID = 1'b0;
        PAR_EN     = 1'b0;
        i = 0;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            checks++;
            if ({TX_OUT, Busy} !== exp) begin
                errors++;
                $display("FAIL parity typ=%0b cycle %0d: tx/busy=%b expected %b",
                         pt, i, {TX_OUT, Busy}, exp);
            end
            i++;
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp;
        int         i;
        P_DATA     = 8'h3C;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        DATA_VALID = 1'b1;
        push_frame(8'h3C, 1'b0, 1'b0);
        push_idle();
        push_frame(8'hC3, 1'b0, 1'b0);
        push_idle();
        @(negedge clk);
        P_DATA = 8'hC3;
        i = 0;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            checks++;
            if ({TX_OUT, Busy} !== exp) begin
                errors++;
                $display("FAIL back_to_back cycle %0d: tx/busy=%b expected %b",
                         i, {TX_OUT, Busy}, exp);
            end
            // Entry DW+3 is the start bit of the second frame: it has been accepted.
            if (i == int'(DW) + 3) DATA_VALID = 1'b0;
            i++;
            @(negedge clk);
        end
    endtask

    task automatic test_change_mid_frame();
        logic [1:0] exp;
        int         i;
        P_DATA     = 8'h00;
        PAR_EN     = 1'b1;
        PAR_TYP    = 1'b0;
        DATA_VALID = 1'b1;
        push_frame(8'h00, 1'b1, 1'b0);
        push_idle();
        @(negedge clk);
        DATA_VALID = 1'b0;
        P_DATA     = 8'hFF;
        PAR_TYP    = 1'b1;
        PAR_EN     = 1'b0;
        i = 0;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            checks++;
            if ({TX_OUT, Busy} !== exp) begin
                errors++;
                $display("FAIL change_mid_frame cycle %0d: tx/busy=%b expected %b",
                         i, {TX_OUT, Busy}, exp);
            end
            i++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [1:0] exp;
        int         i;
        P_DATA     = 8'h5A;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        DATA_VALID = 1'b1;
        push_frame(8'h5A, 1'b0, 1'b0);
        @(negedge clk);
        DATA_VALID = 1'b0;
        // Start bit plus data bits 0..3; reset is applied while bit 3 is on the line.
        for (int k = 0; k < 5; k++) begin
            exp = exp_q.pop_front();
            checks++;
            if ({TX_OUT, Busy} !== exp) begin
                errors++;
                $display("FAIL pre_abort cycle %0d: tx/busy=%b expected %b", k, {TX_OUT, Busy}, exp);
            end
            if (k < 4) @(negedge clk);
        end
        RST = 1'b1;
        exp_q.delete();
        @(negedge clk);
        exp = 2'b10;
        checks++;
        if ({TX_OUT, Busy} !== exp) begin
            errors++;
            $display("FAIL abort: tx/busy=%b expected %b", {TX_OUT, Busy}, exp);
        end
        RST        = 1'b0;
        P_DATA     = 8'h81;
        DATA_VALID = 1'b1;
        push_frame(8'h81, 1'b0, 1'b0);
        push_idle();
        @(negedge clk);
        DATA_VALID = 1'b0;
        i = 0;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            checks++;
            if ({TX_OUT, Busy} !== exp) begin
                errors++;
                $display("FAIL after_abort cycle %0d: tx/busy=%b expected %b",
                         i, {TX_OUT, Busy}, exp);
            end
            i++;
            @(negedge clk);
        end
    endtask

    initial begin
        RST        = 1'b1;
        P_DATA     = '0;
        DATA_VALID = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        test_reset();
        test_no_parity();
        test_parity(1'b0);
        test_parity(1'b1);
        test_back_to_back();
        test_change_mid_frame();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
